key_event: RTL and testbench

- Sits directly downstream of the chatter-removal (debounce) stage and consumes its clean, clk-synchronous key level.
- Converts the level into single-cycle events: press, release, long-press and auto-repeat.
- Also provides a held-level flag and a wrapping press counter for the control logic.

---
 rtl/key_event_pkg.sv | 15 +
 rtl/key_hold_timer.sv | 33 +++
 rtl/key_event.sv | 144 ++++++++++++++
 tb/tb_key_event.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and default sizing for the key event block.
// Imported by the FSM top and its hold timer.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  localparam int LONG_CYCLES_DEF   = 8;
  localparam int REPEAT_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/key_hold_timer.sv
// Loadable, clearable up-counter with a terminal-count flag.
// Clear wins over load, load wins over increment.
module key_hold_timer
  import key_event_pkg::*;
#(
  parameter int W     = 3,
  parameter int LIMIT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(LIMIT));

endmodule

// File: rtl/key_event.sv
// Turns a debounced key level into press, release, long-press
// and auto-repeat pulses, plus a held flag and press counter.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in,
  output logic             press,
  // release/repeat are SV keywords, hence the suffix
  output logic             release_pulse,
  output logic             long_press,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int HW = $clog2(LONG_CYCLES);
  localparam int RW =
    (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES);

  state_t state, state_nx;

  logic press_nx, rel_nx, long_nx, rep_nx;
  logic [CNT_W-1:0] cnt_nx;

  logic h_clr, h_load, h_inc, h_tc;
  logic r_clr, r_inc, r_tc;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;

  key_hold_timer #(
    .W     (HW),
    .LIMIT (LONG_CYCLES - 1)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clr      (h_clr),
    .load     (h_load),
    .load_val (HW'(1)),
    .inc      (h_inc),
    .count    (hold_cnt),
    .tc       (h_tc)
  );

  key_hold_timer #(
    .W     (RW),
    .LIMIT (REPEAT_CYCLES - 1)
  ) u_rep (
    .clk      (clk),
    .rst      (rst),
    .clr      (r_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (r_inc),
    .count    (rep_cnt),
    .tc       (r_tc)
  );

  always_comb begin
    state_nx = state;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    long_nx  = 1'b0;
    rep_nx   = 1'b0;
    cnt_nx   = press_count;
    h_clr    = 1'b0;
    h_load   = 1'b0;
    h_inc    = 1'b0;
    r_clr    = 1'b0;
    r_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_in) begin
          state_nx = PRESSED;
          press_nx = 1'b1;
          h_load   = 1'b1;
          cnt_nx   = press_count + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_in) begin
          if (h_tc) begin
            state_nx = LONG;
            long_nx  = 1'b1;
            r_clr    = 1'b1;
          end else begin
            h_inc = 1'b1;
          end
        end else begin
          state_nx = IDLE;
          rel_nx   = 1'b1;
          h_clr    = 1'b1;
          r_clr    = 1'b1;
        end
      end
      LONG: begin
        if (key_in) begin
          if (r_tc) begin
            rep_nx = 1'b1;
            r_clr  = 1'b1;
          end else begin
            r_inc = 1'b1;
          end
        end else begin
          state_nx = IDLE;
          rel_nx   = 1'b1;
          h_clr    = 1'b1;
          r_clr    = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        h_clr    = 1'b1;
        r_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_nx;
      press         <= press_nx;
      release_pulse <= rel_nx;
      long_press    <= long_nx;
      repeat_pulse  <= rep_nx;
      press_count   <= cnt_nx;
    end
  end

  assign held = (state != IDLE);

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: a run-length model of the key
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_key_event;

  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_in = 1'b0;
  logic          press, release_pulse, long_press;
  logic          repeat_pulse, held;
  logic [CW-1:0] press_count;

  typedef struct {
    bit          p;
    bit          r;
    bit          l;
    bit          rp;
    bit          h;
    bit [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   run    = 0;
  bit [CW-1:0] m_cnt = '0;

  key_event #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Model: count consecutive high samples since the press.
  task automatic model(input bit k);
    exp_t e;
    e = '{default: 0};
    if (k) begin
      run++;
      if (run == 1) begin
        e.p = 1;
        m_cnt = m_cnt + 1'b1;
      end
      if (run == LONG) e.l = 1;
      if (run > LONG && (run - LONG) % REP == 0) e.rp = 1;
    end else begin
      if (run > 0) e.r = 1;
      run = 0;
    end
    e.h   = (run > 0);
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic drive(input bit k);
    @(negedge clk);
    key_in = k;
    @(posedge clk);
    model(k);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("press", int'(press), int'(e.p));
      chk("release", int'(release_pulse), int'(e.r));
      chk("long_press", int'(long_press), int'(e.l));
      chk("repeat", int'(repeat_pulse), int'(e.rp));
      chk("held", int'(held), int'(e.h));
      chk("press_count", int'(press_count), int'(e.cnt));
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_press"}, int'(press), 0);
    chk({tag, "_release"}, int'(release_pulse), 0);
    chk({tag, "_long"}, int'(long_press), 0);
    chk({tag, "_repeat"}, int'(repeat_pulse), 0);
    chk({tag, "_held"}, int'(held), 0);
    chk({tag, "_count"}, int'(press_count), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("in_reset");
    #2 rst = 1'b0;

    repeat (5) drive(1'b0);

    drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    repeat (16) drive(1'b1);
    repeat (3) drive(1'b0);

    drive(1'b1); drive(1'b0); drive(1'b1);
    drive(1'b0); drive(1'b1); drive(1'b0);
    drive(1'b0);

    repeat (5) drive(1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    run   = 0;
    m_cnt = '0;
    @(posedge clk);
    model(1'b1 && 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    model(1'b1);
    repeat (3) drive(1'b1);
    drive(1'b0);

    while (m_cnt != '1) begin
      drive(1'b1);
      drive(1'b0);
    end
    drive(1'b1);
    drive(1'b0);

    for (int b = 0; b < 60; b++) begin
      int hi, lo;
      hi = $urandom_range(1, 22);
      lo = $urandom_range(1, 4);
      repeat (hi) drive(1'b1);
      repeat (lo) drive(1'b0);
    end

    @(negedge clk);
    #2 chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
